// File: rtl/y_writer_if.sv
`default_nettype none
// ============================================================================
//  y_writer_if
//  AXI4 write channels for the Y vector plus the 64-bit Y result stream.
//  Rev 1.0
// ============================================================================
interface y_writer_if;
   logic        m_axi_Y_awid;
   logic [47:0] m_axi_Y_awaddr;
   logic [7:0]  m_axi_Y_awlen;
   logic [2:0]  m_axi_Y_awsize;
   logic [1:0]  m_axi_Y_awburst;
   logic        m_axi_Y_awlock;
   logic [3:0]  m_axi_Y_awcache;
   logic [2:0]  m_axi_Y_awprot;
   logic [3:0]  m_axi_Y_awqos;
   logic        m_axi_Y_awvalid;
   logic        m_axi_Y_awready;
   logic [63:0] m_axi_Y_wdata;
   logic [7:0]  m_axi_Y_wstrb;
   logic        m_axi_Y_wlast;
   logic        m_axi_Y_wvalid;
   logic        m_axi_Y_wready;
   logic        m_axi_Y_bid;
   logic [1:0]  m_axi_Y_bresp;
   logic        m_axi_Y_bvalid;
   logic        m_axi_Y_bready;
   logic        input_valid;
   logic        input_ready;
   logic [63:0] input_data;

   modport master (
      output m_axi_Y_awid, m_axi_Y_awaddr, m_axi_Y_awlen, m_axi_Y_awsize,
             m_axi_Y_awburst, m_axi_Y_awlock, m_axi_Y_awcache, m_axi_Y_awprot,
             m_axi_Y_awqos, m_axi_Y_awvalid, m_axi_Y_wdata, m_axi_Y_wstrb,
             m_axi_Y_wlast, m_axi_Y_wvalid, m_axi_Y_bready, input_ready,
      input  m_axi_Y_awready, m_axi_Y_wready, m_axi_Y_bid, m_axi_Y_bresp,
             m_axi_Y_bvalid, input_valid, input_data
   );

   modport slave (
      input  m_axi_Y_awid, m_axi_Y_awaddr, m_axi_Y_awlen, m_axi_Y_awsize,
             m_axi_Y_awburst, m_axi_Y_awlock, m_axi_Y_awcache, m_axi_Y_awprot,
             m_axi_Y_awqos, m_axi_Y_awvalid, m_axi_Y_wdata, m_axi_Y_wstrb,
             m_axi_Y_wlast, m_axi_Y_wvalid, m_axi_Y_bready, input_ready,
      output m_axi_Y_awready, m_axi_Y_wready, m_axi_Y_bid, m_axi_Y_bresp,
             m_axi_Y_bvalid, input_valid, input_data
   );
endinterface
`default_nettype wire

// File: rtl/y_writer.sv
`default_nettype none
// ============================================================================
//  y_writer
//  Writes the packed Y result stream to memory as INCR bursts, one in flight.
//  Rev 1.0
// ============================================================================
module y_writer #(
   parameter logic [31:0] YVAL_BASE_ADDR = 32'h40000000,
   parameter int          BURST_LEN      = 16
) (
   input  wire         clk,
   input  wire         rstn,
   input  wire         Write_Begin,
   input  wire  [31:0] Write_Length,
   output logic        Write_Busy,
   output logic        Write_Done,
   output logic        Write_Err,
   y_writer_if.master  bus
);

   localparam logic [2:0]  c_S_IDLE = 3'd0;
   localparam logic [2:0]  c_S_ADDR = 3'd1;
   localparam logic [2:0]  c_S_DATA = 3'd2;
   localparam logic [2:0]  c_S_RESP = 3'd3;
   localparam logic [2:0]  c_S_DONE = 3'd4;

   localparam logic [31:0] c_BURST_LEN_W = 32'(BURST_LEN);
   localparam logic [8:0]  c_BURST_LEN_S = 9'(BURST_LEN);
   localparam logic [47:0] c_BASE_ADDR   = {16'h0000, YVAL_BASE_ADDR};

   logic [2:0]  r_state;
   logic [2:0]  w_state_next;
   logic [31:0] r_remaining;
   logic [47:0] r_addr;
   logic [47:0] r_awaddr;
   logic [7:0]  r_awlen;
   logic [8:0]  r_burst;
   logic [8:0]  r_beat;
   logic        r_err;

   logic [31:0] w_rem_src;
   logic [8:0]  w_burst_next;
   logic [7:0]  w_awlen_next;
   logic        w_last_beat;
   logic        w_awvalid;
   logic        w_wvalid;
   logic        w_wlast;
   logic        w_bready;
   logic        w_input_ready;
   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_b_hs;
   logic        w_unused;

   // Next burst size comes from the job length when starting, else from what is left.
   assign w_rem_src    = (r_state == c_S_IDLE) ? Write_Length : r_remaining;
   assign w_burst_next = (w_rem_src >= c_BURST_LEN_W) ? c_BURST_LEN_S : w_rem_src[8:0];
   assign w_awlen_next = w_burst_next[7:0] - 8'd1;
   assign w_last_beat  = (r_beat == (r_burst - 9'd1));

   assign w_aw_hs = w_awvalid & bus.m_axi_Y_awready;
   assign w_w_hs  = w_wvalid  & bus.m_axi_Y_wready;
   assign w_b_hs  = w_bready  & bus.m_axi_Y_bvalid;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (Write_Begin) begin
               w_state_next = (Write_Length == 32'd0) ? c_S_DONE : c_S_ADDR;
            end
         end
         c_S_ADDR: begin
            if (w_aw_hs) w_state_next = c_S_DATA;
         end
         c_S_DATA: begin
            if (w_w_hs && w_last_beat) w_state_next = c_S_RESP;
         end
         c_S_RESP: begin
            if (w_b_hs) begin
               w_state_next = (r_remaining != 32'd0) ? c_S_ADDR : c_S_DONE;
            end
         end
         c_S_DONE: w_state_next = c_S_IDLE;
         default:  w_state_next = c_S_IDLE;
      endcase
   end

   always_comb begin
      w_awvalid     = 1'b0;
      w_wvalid      = 1'b0;
      w_wlast       = 1'b0;
      w_bready      = 1'b0;
      w_input_ready = 1'b0;
      Write_Busy    = 1'b0;
      Write_Done    = 1'b0;
      case (r_state)
         c_S_ADDR: begin
            w_awvalid  = 1'b1;
            Write_Busy = 1'b1;
         end
         c_S_DATA: begin
            // Stream passes straight through to the W channel with no buffering.
            w_wvalid      = bus.input_valid;
            w_input_ready = bus.m_axi_Y_wready;
            w_wlast       = w_last_beat;
            Write_Busy    = 1'b1;
         end
         c_S_RESP: begin
            w_bready   = 1'b1;
            Write_Busy = 1'b1;
         end
         c_S_DONE: begin
            Write_Done = 1'b1;
            Write_Busy = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_remaining <= '0;
         r_addr      <= '0;
         r_awaddr    <= '0;
         r_awlen     <= '0;
         r_burst     <= '0;
         r_beat      <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            c_S_IDLE: begin
               if (Write_Begin) begin
                  r_remaining <= Write_Length;
                  r_addr      <= c_BASE_ADDR;
                  r_err       <= 1'b0;
                  if (w_rem_src != 32'd0) begin
                     r_awaddr <= c_BASE_ADDR;
                     r_awlen  <= w_awlen_next;
                     r_burst  <= w_burst_next;
                  end
               end
            end
            c_S_ADDR: begin
               if (w_aw_hs) r_beat <= '0;
            end
            c_S_DATA: begin
               if (w_w_hs) begin
                  if (w_last_beat) begin
                     r_remaining <= r_remaining - {23'd0, r_burst};
                     r_addr      <= r_addr + {36'd0, r_burst, 3'b000};
                  end else begin
                     r_beat <= r_beat + 9'd1;
                  end
               end
            end
            c_S_RESP: begin
               if (w_b_hs) begin
                  // Errors are recorded but never abort the remaining bursts.
                  r_err <= r_err | (bus.m_axi_Y_bresp != 2'b00);
                  if (w_rem_src != 32'd0) begin
                     r_awaddr <= r_addr;
                     r_awlen  <= w_awlen_next;
                     r_burst  <= w_burst_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign Write_Err = r_err;

   assign bus.m_axi_Y_awid    = 1'b0;
   assign bus.m_axi_Y_awaddr  = r_awaddr;
   assign bus.m_axi_Y_awlen   = r_awlen;
   assign bus.m_axi_Y_awsize  = 3'd3;
   assign bus.m_axi_Y_awburst = 2'd1;
   assign bus.m_axi_Y_awlock  = 1'b0;
   assign bus.m_axi_Y_awcache = 4'b0011;
   assign bus.m_axi_Y_awprot  = 3'd0;
   assign bus.m_axi_Y_awqos   = 4'd0;
   assign bus.m_axi_Y_awvalid = w_awvalid;
   assign bus.m_axi_Y_wdata   = bus.input_data;
   assign bus.m_axi_Y_wstrb   = 8'hFF;
   assign bus.m_axi_Y_wlast   = w_wlast;
   assign bus.m_axi_Y_wvalid  = w_wvalid;
   assign bus.m_axi_Y_bready  = w_bready;
   assign bus.input_ready     = w_input_ready;

   assign w_unused = bus.m_axi_Y_bid;

endmodule
`default_nettype wire

// File: tb/tb_y_writer.sv
`default_nettype none
// ============================================================================
//  tb_y_writer
//  Directed bench: AXI slave + stream source model, per-scenario checking tasks.
//  Rev 1.0
// ============================================================================
module tb_y_writer;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        Write_Begin = 1'b0;
   logic [31:0] Write_Length = 32'd0;
   logic        Write_Busy;
   logic        Write_Done;
   logic        Write_Err;

   always #5 clk = ~clk;

   y_writer_if bus();

   y_writer #(.YVAL_BASE_ADDR(32'h40000000), .BURST_LEN(16)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .Write_Begin  (Write_Begin),
      .Write_Length (Write_Length),
      .Write_Busy   (Write_Busy),
      .Write_Done   (Write_Done),
      .Write_Err    (Write_Err),
      .bus          (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   bit          stall_mode   = 1'b0;
   int          src_len      = 0;
   logic [63:0] data_base    = 64'd0;
   int          err_resp_idx = -1;

   int          src_idx      = 0;
   int          b_pending    = 0;
   int          b_count      = 0;
   int          done_cnt     = 0;
   int          aw_unstable  = 0;
   int          in_ready_bad = 0;
   bit          aw_hold      = 1'b0;
   logic [47:0] hold_addr    = '0;
   logic [7:0]  hold_len     = '0;
   logic [47:0] aw_addr_q[$];
   logic [7:0]  aw_len_q[$];
   logic [63:0] w_data_q[$];
   logic        w_last_q[$];

   // Slave and source drivers update just after each rising edge.
   initial begin
      bus.m_axi_Y_awready = 1'b0;
      bus.m_axi_Y_wready  = 1'b0;
      bus.m_axi_Y_bvalid  = 1'b0;
      bus.m_axi_Y_bresp   = 2'b00;
      bus.m_axi_Y_bid     = 1'b0;
      bus.input_valid     = 1'b0;
      bus.input_data      = 64'd0;
      forever begin
         @(posedge clk);
         #1;
         bus.m_axi_Y_awready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.m_axi_Y_wready  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.input_valid     = (src_idx < src_len) && (stall_mode ? 1'($urandom_range(0, 1)) : 1'b1);
         bus.input_data      = data_base + 64'(src_idx);
         bus.m_axi_Y_bvalid  = (b_pending > 0) && (stall_mode ? 1'($urandom_range(0, 1)) : 1'b1);
         bus.m_axi_Y_bresp   = (b_count == err_resp_idx) ? 2'b10 : 2'b00;
      end
   end

   // Monitor: handshakes that will complete at the next rising edge.
   always @(negedge clk) begin
      if (aw_hold && (bus.m_axi_Y_awvalid !== 1'b1 || bus.m_axi_Y_awaddr !== hold_addr ||
                      bus.m_axi_Y_awlen !== hold_len))
         aw_unstable <= aw_unstable + 1;
      aw_hold   <= bus.m_axi_Y_awvalid && !bus.m_axi_Y_awready;
      hold_addr <= bus.m_axi_Y_awaddr;
      hold_len  <= bus.m_axi_Y_awlen;
      if (bus.m_axi_Y_awvalid && bus.m_axi_Y_awready) begin
         aw_addr_q.push_back(bus.m_axi_Y_awaddr);
         aw_len_q.push_back(bus.m_axi_Y_awlen);
      end
      if (bus.m_axi_Y_wvalid && bus.m_axi_Y_wready) begin
         w_data_q.push_back(bus.m_axi_Y_wdata);
         w_last_q.push_back(bus.m_axi_Y_wlast);
         if (bus.m_axi_Y_wlast) b_pending <= b_pending + 1;
      end
      if (bus.input_valid && bus.input_ready) src_idx <= src_idx + 1;
      if (bus.m_axi_Y_bvalid && bus.m_axi_Y_bready) begin
         b_pending <= b_pending - 1;
         b_count   <= b_count + 1;
      end
      if (Write_Done) done_cnt <= done_cnt + 1;
      if (bus.input_ready && (!Write_Busy || bus.m_axi_Y_awvalid || bus.m_axi_Y_bready || Write_Done))
         in_ready_bad <= in_ready_bad + 1;
   end

   task automatic run_job(input logic [31:0] len, input int maxcyc,
                          output bit ok, output int lat, output logic err0);
      @(posedge clk);
      #1;
      src_len      = src_idx + int'(len);
      Write_Length = len;
      Write_Begin  = 1'b1;
      @(posedge clk);
      #1;
      Write_Begin = 1'b0;
      ok   = 1'b0;
      lat  = 0;
      err0 = 1'bx;
      for (int c = 0; c < maxcyc; c++) begin
         @(negedge clk);
         if (c == 0) err0 = Write_Err;
         lat = c + 1;
         if (Write_Done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] ctl;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ctl = {bus.m_axi_Y_awvalid, bus.m_axi_Y_wvalid, bus.m_axi_Y_wlast, bus.m_axi_Y_bready,
             bus.input_ready, Write_Busy, Write_Done, Write_Err};
      n_checks++;
      if (ctl !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b required 00000000", ctl);
      end
      n_checks++;
      if (bus.m_axi_Y_awaddr !== 48'd0 || bus.m_axi_Y_awlen !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_aw: got addr %h len %h required 0/0", bus.m_axi_Y_awaddr, bus.m_axi_Y_awlen);
      end
      n_checks++;
      if ({bus.m_axi_Y_awsize, bus.m_axi_Y_awburst, bus.m_axi_Y_awcache, bus.m_axi_Y_wstrb} !==
          {3'd3, 2'd1, 4'b0011, 8'hFF}) begin
         n_fail++;
         $display("FAIL const_fields: got size %0d burst %0d cache %b strb %h required 3/1/0011/ff",
                  bus.m_axi_Y_awsize, bus.m_axi_Y_awburst, bus.m_axi_Y_awcache, bus.m_axi_Y_wstrb);
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic test_two_bursts();
      bit ok; int lat; logic e0; int bad;
      int aw0 = aw_addr_q.size();
      int w0  = w_data_q.size();
      int s0  = src_idx;
      int d0  = done_cnt;
      data_base = 64'h1111_2222_0000_0000;
      run_job(32'd32, 200, ok, lat, e0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (!ok || lat > 37) begin
         n_fail++;
         $display("FAIL two_done_latency: got done=%0b after %0d cycles required done within 37", ok, lat);
      end
      n_checks++;
      if (aw_addr_q.size() - aw0 != 2) begin
         n_fail++;
         $display("FAIL two_aw_count: got %0d required 2", aw_addr_q.size() - aw0);
      end else begin
         n_checks++;
         if (aw_addr_q[aw0] !== 48'h40000000 || aw_len_q[aw0] !== 8'd15 ||
             aw_addr_q[aw0+1] !== 48'h40000080 || aw_len_q[aw0+1] !== 8'd15) begin
            n_fail++;
            $display("FAIL two_aw_fields: got %h/%0d %h/%0d required 40000000/15 40000080/15",
                     aw_addr_q[aw0], aw_len_q[aw0], aw_addr_q[aw0+1], aw_len_q[aw0+1]);
         end
      end
      n_checks++;
      if (w_data_q.size() - w0 != 32) begin
         n_fail++;
         $display("FAIL two_w_count: got %0d required 32", w_data_q.size() - w0);
      end else begin
         bad = 0;
         for (int i = 0; i < 32; i++) begin
            if (w_data_q[w0+i] !== data_base + 64'(s0 + i)) bad++;
            if (w_last_q[w0+i] !== (i == 15 || i == 31)) bad++;
         end
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL two_w_data_last: got %0d bad beats required 0", bad);
         end
      end
      n_checks++;
      if (done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL two_done_pulses: got %0d required 1", done_cnt - d0);
      end
   endtask

   task automatic test_short_burst();
      bit ok; int lat; logic e0; int bad;
      int aw0 = aw_addr_q.size();
      int w0  = w_data_q.size();
      int s0  = src_idx;
      data_base = 64'hABCD_0000_0000_0100;
      run_job(32'd20, 200, ok, lat, e0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL short_timeout: got no Write_Done required Write_Done");
      end
      n_checks++;
      if (aw_addr_q.size() - aw0 != 2) begin
         n_fail++;
         $display("FAIL short_aw_count: got %0d required 2", aw_addr_q.size() - aw0);
      end else begin
         n_checks++;
         if (aw_addr_q[aw0] !== 48'h40000000 || aw_len_q[aw0] !== 8'd15 ||
             aw_addr_q[aw0+1] !== 48'h40000080 || aw_len_q[aw0+1] !== 8'd3) begin
            n_fail++;
            $display("FAIL short_aw_fields: got %h/%0d %h/%0d required 40000000/15 40000080/3",
                     aw_addr_q[aw0], aw_len_q[aw0], aw_addr_q[aw0+1], aw_len_q[aw0+1]);
         end
      end
      n_checks++;
      if (w_data_q.size() - w0 != 20) begin
         n_fail++;
         $display("FAIL short_w_count: got %0d required 20", w_data_q.size() - w0);
      end else begin
         bad = 0;
         for (int i = 0; i < 20; i++) begin
            if (w_data_q[w0+i] !== data_base + 64'(s0 + i)) bad++;
            if (w_last_q[w0+i] !== (i == 15 || i == 19)) bad++;
         end
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL short_w_data_last: got %0d bad beats required 0", bad);
         end
      end
   endtask

   task automatic test_zero_length();
      bit ok; int lat; logic e0;
      int aw0 = aw_addr_q.size();
      int w0  = w_data_q.size();
      int d0  = done_cnt;
      run_job(32'd0, 10, ok, lat, e0);
      n_checks++;
      if (!ok || lat > 2 || Write_Busy !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_done: got done=%0b lat=%0d busy=%b required done within 2 with busy 1",
                  ok, lat, Write_Busy);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (aw_addr_q.size() != aw0 || w_data_q.size() != w0 || done_cnt - d0 != 1 || Write_Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_activity: got aw=%0d w=%0d done=%0d busy=%b required 0/0/1/0",
                  aw_addr_q.size() - aw0, w_data_q.size() - w0, done_cnt - d0, Write_Busy);
      end
   endtask

   task automatic test_stalls();
      bit ok; int lat; logic e0; int bad;
      logic [47:0] exp_addr [4] = '{48'h40000000, 48'h40000080, 48'h40000100, 48'h40000180};
      logic [7:0]  exp_len  [4] = '{8'd15, 8'd15, 8'd15, 8'd1};
      int aw0 = aw_addr_q.size();
      int w0  = w_data_q.size();
      int s0  = src_idx;
      int d0  = done_cnt;
      int u0  = aw_unstable;
      int r0  = in_ready_bad;
      data_base  = 64'h5A5A_0000_1000_0000;
      stall_mode = 1'b1;
      run_job(32'd50, 3000, ok, lat, e0);
      stall_mode = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (!ok || done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL stall_done: got done=%0b pulses=%0d required 1/1", ok, done_cnt - d0);
      end
      n_checks++;
      if (aw_addr_q.size() - aw0 != 4) begin
         n_fail++;
         $display("FAIL stall_aw_count: got %0d required 4", aw_addr_q.size() - aw0);
      end else begin
         bad = 0;
         for (int i = 0; i < 4; i++)
            if (aw_addr_q[aw0+i] !== exp_addr[i] || aw_len_q[aw0+i] !== exp_len[i]) bad++;
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_aw_fields: got %0d wrong bursts required 0", bad);
         end
      end
      n_checks++;
      if (w_data_q.size() - w0 != 50) begin
         n_fail++;
         $display("FAIL stall_w_count: got %0d required 50", w_data_q.size() - w0);
      end else begin
         bad = 0;
         for (int i = 0; i < 50; i++) begin
            if (w_data_q[w0+i] !== data_base + 64'(s0 + i)) bad++;
            if (w_last_q[w0+i] !== ((i % 16) == 15 || i == 49)) bad++;
         end
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_w_data_last: got %0d bad beats required 0", bad);
         end
      end
      n_checks++;
      if (aw_unstable != u0 || in_ready_bad != r0) begin
         n_fail++;
         $display("FAIL stall_protocol: got aw_unstable=%0d ready_outside_data=%0d required 0/0",
                  aw_unstable - u0, in_ready_bad - r0);
      end
   endtask

   task automatic test_bresp_error();
      bit ok; int lat; logic e0;
      int aw0 = aw_addr_q.size();
      err_resp_idx = b_count;
      data_base    = 64'h0EE0_0000_0000_0000;
      run_job(32'd32, 200, ok, lat, e0);
      err_resp_idx = -1;
      @(negedge clk);
      n_checks++;
      if (!ok || aw_addr_q.size() - aw0 != 2 || Write_Err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: got done=%0b aw=%0d err=%b required 1/2/1",
                  ok, aw_addr_q.size() - aw0, Write_Err);
      end
      aw0 = aw_addr_q.size();
      run_job(32'd3, 100, ok, lat, e0);
      @(negedge clk);
      n_checks++;
      if (e0 !== 1'b0 || Write_Err !== 1'b0 || !ok) begin
         n_fail++;
         $display("FAIL err_clear: got err_at_start=%b err_end=%b done=%0b required 0/0/1", e0, Write_Err, ok);
      end
      n_checks++;
      if (aw_addr_q.size() - aw0 != 1 || aw_len_q[aw_len_q.size()-1] !== 8'd2 ||
          aw_addr_q[aw_addr_q.size()-1] !== 48'h40000000) begin
         n_fail++;
         $display("FAIL err_next_job_aw: got count=%0d required one burst 40000000/2", aw_addr_q.size() - aw0);
      end
   endtask

   task automatic test_mid_reset();
      bit ok; int lat; logic e0; int bad; logic [7:0] ctl;
      int w0 = w_data_q.size();
      int aw0; int s0;
      data_base = 64'h7777_0000_0000_0000;
      @(posedge clk);
      #1;
      src_len      = src_idx + 32;
      Write_Length = 32'd32;
      Write_Begin  = 1'b1;
      @(posedge clk);
      #1;
      Write_Begin = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (w_data_q.size() - w0 >= 5) break;
      end
      n_checks++;
      if (w_data_q.size() - w0 < 5) begin
         n_fail++;
         $display("FAIL midrst_start: got %0d beats required at least 5", w_data_q.size() - w0);
      end
      @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      ctl = {bus.m_axi_Y_awvalid, bus.m_axi_Y_wvalid, bus.m_axi_Y_wlast, bus.m_axi_Y_bready,
             bus.input_ready, Write_Busy, Write_Done, Write_Err};
      n_checks++;
      if (ctl !== 8'h00 || bus.m_axi_Y_awaddr !== 48'd0 || bus.m_axi_Y_awlen !== 8'd0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got ctl %b addr %h len %h required all 0",
                  ctl, bus.m_axi_Y_awaddr, bus.m_axi_Y_awlen);
      end
      src_len   = src_idx;
      aw0       = aw_addr_q.size();
      w0        = w_data_q.size();
      s0        = src_idx;
      data_base = 64'h8888_0000_0000_0000;
      run_job(32'd16, 200, ok, lat, e0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (!ok || aw_addr_q.size() - aw0 != 1 || w_data_q.size() - w0 != 16) begin
         n_fail++;
         $display("FAIL midrst_restart: got done=%0b aw=%0d w=%0d required 1/1/16",
                  ok, aw_addr_q.size() - aw0, w_data_q.size() - w0);
      end else begin
         bad = 0;
         for (int i = 0; i < 16; i++)
            if (w_data_q[w0+i] !== data_base + 64'(s0 + i) || w_last_q[w0+i] !== (i == 15)) bad++;
         n_checks++;
         if (aw_addr_q[aw0] !== 48'h40000000 || aw_len_q[aw0] !== 8'd15 || bad != 0) begin
            n_fail++;
            $display("FAIL midrst_restart_fields: got %h/%0d bad=%0d required 40000000/15 bad=0",
                     aw_addr_q[aw0], aw_len_q[aw0], bad);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test required end before 2ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_two_bursts();
      test_short_burst();
      test_zero_length();
      test_stalls();
      test_bresp_error();
      test_mid_reset();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/y_writer.md
Name: y_writer

Overview:
- Write-side counterpart of the Xi/colIndex read path in the SpMV row kernel.
- Accepts the 64-bit packed Y result stream from the kernel's output data mux and writes it to device memory through an AXI4 write master.
- Splits a job into incrementing bursts of at most BURST_LEN beats, with one burst outstanding at a time.
- Reports completion and any write-response error to the kernel controller.

Parameters:
- YVAL_BASE_ADDR, 32'h40000000, byte base address of the Y vector. Must be aligned to BURST_LEN*8.
- BURST_LEN, 16, maximum beats per burst; legal values are powers of two, 1..256.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- Write_Begin  in  1  one-cycle start pulse; ignored unless idle
- Write_Length  in  32  number of 64-bit beats in the job; sampled on an accepted Write_Begin
- Write_Busy  out  1  high from the cycle after an accepted Write_Begin until Write_Done
- Write_Done  out  1  one-cycle pulse when the job completes
- Write_Err  out  1  sticky; set on any bresp != 0; cleared on an accepted Write_Begin
- input_valid  in  1  Y stream valid
- input_ready  out  1  Y stream ready
- input_data  in  64  Y stream data
- m_axi_Y_awid  out  1  constant 0
- m_axi_Y_awaddr  out  48  burst start address
- m_axi_Y_awlen  out  8  beats-1
- m_axi_Y_awsize  out  3  constant 3 (8 bytes)
- m_axi_Y_awburst  out  2  constant 1 (INCR)
- m_axi_Y_awlock  out  1  constant 0
- m_axi_Y_awcache  out  4  constant 4'b0011
- m_axi_Y_awprot  out  3  constant 0
- m_axi_Y_awqos  out  4  constant 0
- m_axi_Y_awvalid  out  1  address valid
- m_axi_Y_awready  in  1  address ready
- m_axi_Y_wdata  out  64  write data
- m_axi_Y_wstrb  out  8  constant 8'hFF
- m_axi_Y_wlast  out  1  last beat of burst
- m_axi_Y_wvalid  out  1  write valid
- m_axi_Y_wready  in  1  write ready
- m_axi_Y_bid  in  1  unused
- m_axi_Y_bresp  in  2  write response
- m_axi_Y_bvalid  in  1  response valid
- m_axi_Y_bready  out  1  response ready

Behaviour:
- Reset: rstn, synchronous, active-low; clock clk.
  - All state, counters and outputs clear to 0: state=IDLE, awvalid, wvalid, wlast, bready, input_ready, Write_Busy, Write_Done, Write_Err, awaddr, awlen.
  - Reset asserted mid-burst abandons the job immediately; the interconnect is reset alongside.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE:
  - Write_Begin=1 latches remaining=Write_Length, sets addr=YVAL_BASE_ADDR, clears Write_Err.
  - Next state is ADDR, or DONE if Write_Length==0.
- ADDR:
  - burst = min(BURST_LEN, remaining).
  - awaddr=addr, awlen=burst-1, awvalid=1; all registered on entry and held stable until awready.
  - On awvalid&awready: go to DATA; beat counter=0.
- DATA:
  - Pass-through with zero added latency: wvalid=input_valid, input_ready=wready, wdata=input_data.
  - wlast=(beat==burst-1), combinational from the registered counter.
  - Each wvalid&wready increments beat.
  - On the last handshake: remaining-=burst, addr+=burst*8 (48-bit add), go to RESP.
  - input_ready is 0 in every state other than DATA.
- RESP:
  - bready=1.
  - On bvalid: Write_Err |= (bresp!=0); go to ADDR if remaining!=0, else DONE.
- DONE: Write_Done=1 for exactly one cycle; go to IDLE.
- Write_Busy=1 in ADDR, DATA, RESP and DONE.
- Write_Begin outside IDLE is ignored.
- A response error does not abort the job; the remaining bursts are still written.
- Bursts never cross a 4 KB boundary, guaranteed by the aligned base and BURST_LEN*8 ≤ 2048.
- Final burst is short when Write_Length is not a multiple of BURST_LEN.
- Throughput: one beat per cycle when input and wready are continuously high. Per-burst overhead is at least 1 AW cycle plus 1 B cycle.

Test Plan:
- Write_Length=32, BURST_LEN=16, input and wready always high -> two AW: 0x40000000/awlen 15, then 0x40000080/awlen 15. 32 W beats with wlast on beats 15 and 31. Data order preserved. Write_Done pulses once.
- Write_Length=20 -> AW awlen 15 at 0x40000000, then awlen 3 at 0x40000080. wlast on the 4th beat of the second burst.
- Write_Length=0 -> no AW/W activity; Write_Done pulses 2 cycles after Write_Begin.
- Random input_valid/wready/awready/bvalid stalls on a 50-beat job -> no data loss or duplication. awaddr/awlen held stable while awvalid && !awready. input_ready never high outside DATA.
- bresp=2'b10 on the first of 2 bursts -> second burst still issued; Write_Err=1 after Done; cleared by the next Write_Begin.
- rstn low for 1 cycle mid-DATA -> all outputs 0 next cycle. A new Write_Begin after reset restarts from YVAL_BASE_ADDR.
